px_frame_writer: RTL
====================

Name: px_frame_writer

Overview:
- Sink end of the filtered pixel stream. Consumes the ready/valid raster stream produced by the low-pass filter (data plus last_x/last_y framing) and writes each pixel into a frame-buffer write port at address {y,x}.
- Checks the framing flags against the configured resolution, counts mismatches, and raises done once the last pixel has been committed to memory.
- Sits between the filter output and the frame-buffer RAM/arbiter.

Parameters:
- XB, 10, x coordinate width; row pitch is 2**XB.
- YB, 10, y coordinate width.
- PB, 8, pixel data width.
- EB, 8, error counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_width  in  XB  frame width minus 1; sampled on start.
- cfg_height  in  YB  frame height minus 1; sampled on start.
- start  in  1  single-cycle pulse; begins a frame.
- px_in_ready  out  1  stream ready.
- px_in_valid  in  1  stream valid.
- px_in_last_x  in  1  last pixel of row.
- px_in_last_y  in  1  pixel is in the last row.
- px_in_data  in  PB  pixel value.
- mem_wr_valid  out  1  write request.
- mem_wr_ready  in  1  write accepted.
- mem_wr_addr  out  XB+YB  write address {y,x}.
- mem_wr_data  out  PB  write data.
- done  out  1  frame fully written; held high.
- err_framing  out  1  sticky framing-mismatch flag.
- err_count  out  EB  saturating framing-mismatch count.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; px_in_ready=0, mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0, done=0, err_framing=0, err_count=0; x/y counters=0.
- Reset mid-frame aborts immediately. Any pending write is dropped with no partial commit.

FSM IDLE -> RUN -> DRAIN -> DONE:
- IDLE: ready=0. On start, latch cfg_width/cfg_height, clear x, y, err_framing, err_count and done, then go to RUN.
- RUN: px_in_ready = !mem_wr_valid || mem_wr_ready. This is combinational from mem_wr_ready and the state. There are no bubbles at full rate.
- A stream beat is accepted when px_in_valid && px_in_ready. On accept, the next cycle has mem_wr_valid=1, mem_wr_addr={y,x}, mem_wr_data=px_in_data. Latency is one cycle from accept to the write request.
- mem_wr_valid clears after a cycle with mem_wr_ready high and no new accept. Addr and data are held stable while valid && !ready.
- Counter update on accept: x=x+1; if x==cfg_width then x=0 and y=y+1.
- Last-pixel accept: accepting x==cfg_width && y==cfg_height moves the FSM to DRAIN.
- DRAIN: px_in_ready=0. When the final write handshakes (mem_wr_valid && mem_wr_ready), go to DONE.
- DONE: done=1, px_in_ready=0, so extra beats are never accepted. start re-enters RUN the same way IDLE does, and done drops the cycle after start.
- start while in RUN or DRAIN is ignored.

Framing check (every accept):
- Expected flags: exp_x = (x==cfg_width), exp_y = (y==cfg_height).
- If px_in_last_x != exp_x or px_in_last_y != exp_y, set err_framing and increment err_count, saturating at 2**EB-1.
- Addressing always follows the internal counters, never the incoming flags. An early or late last flag does not shorten or extend the frame.

Width rules:
- The address is the concatenation y[YB-1:0], x[XB-1:0]; no multiplier.
- 1x1 frame (cfg 0,0): the first accept goes straight to DRAIN.
- Width or height of 2**XB or 2**YB (cfg all ones) must work, and counters wrap cleanly to 0.

Optional Feature:
- Macro: PX_FRAME_WRITER_CHECKSUM_EN.
- Defined: adds output port frame_sum [15:0]. It is the running sum, mod 2**16, of px_in_data over accepted beats. It is cleared on start and on reset, and is valid and stable when done=1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- 4x4 frame, both rates 100%, correct flags, data = x+4y -> 16 writes at addr {y,x} with matching data, back to back. done rises one cycle after the write to addr {3,3} handshakes. err_count=0.
- 5x3 frame, mem_wr_ready toggling 1-of-3 cycles, px_in_valid random 50% -> addr/data held stable while stalled, no beat lost or duplicated, px_in_ready low whenever mem_wr_valid && !mem_wr_ready.
- 4x4 frame with last_x asserted at x=2 of row 1 and last_y missing on the final pixel -> err_framing=1, err_count=2, still exactly 16 writes, done=1.
- rst_n pulled low after 7 of 16 beats, then start with cfg 3x2 -> all outputs reset asynchronously, new frame writes addr {0,0}..{2,3} and completes correctly.
- cfg 0,0 single pixel, then 3 extra valid beats after done -> one write to addr 0, px_in_ready stays 0, done held. With the macro defined, frame_sum equals the pixel value.
- Macro defined, 1024x24 frame with all data 255 -> frame_sum = (24576*255) mod 65536 = 40960, err_count=0.

Source files
------------

// File: rtl/px_frame_writer.sv
// px_frame_writer: sink end of the filtered pixel stream.
// Accepts a ready/valid raster stream with last_x/last_y framing, writes each
// pixel to a frame-buffer write port at address {y,x}, checks the framing
// flags against the configured resolution and raises done once the final
// pixel has been committed to memory.
// Optional feature: define PX_FRAME_WRITER_CHECKSUM_EN to add a 16-bit
// running sum of accepted pixel values on output port frame_sum.
module px_frame_writer #(
    parameter int XB = 10,
    parameter int YB = 10,
    parameter int PB = 8,
    parameter int EB = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XB-1:0]   cfg_width,
    input  logic [YB-1:0]   cfg_height,
    input  logic            start,
    output logic            px_in_ready,
    input  logic            px_in_valid,
    input  logic            px_in_last_x,
    input  logic            px_in_last_y,
    input  logic [PB-1:0]   px_in_data,
    output logic            mem_wr_valid,
    input  logic            mem_wr_ready,
    output logic [XB+YB-1:0] mem_wr_addr,
    output logic [PB-1:0]   mem_wr_data,
    output logic            done,
    output logic            err_framing,
    output logic [EB-1:0]   err_count
`ifdef PX_FRAME_WRITER_CHECKSUM_EN
    ,
    output logic [15:0]     frame_sum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [XB-1:0] X_ONE   = {{(XB-1){1'b0}}, 1'b1};
    localparam logic [YB-1:0] Y_ONE   = {{(YB-1){1'b0}}, 1'b1};
    localparam logic [EB-1:0] E_ONE   = {{(EB-1){1'b0}}, 1'b1};
    localparam logic [EB-1:0] E_MAX   = {EB{1'b1}};

    state_t          state;
    logic [XB-1:0]   x;
    logic [YB-1:0]   y;
    logic [XB-1:0]   width;
    logic [YB-1:0]   height;

    logic            accept;
    logic            at_last_x;
    logic            at_last_y;
    logic            frame_error;
    logic            start_frame;
    logic            write_done;

    // Ready is combinational so a stalled write port back-pressures the stream
    // in the same cycle, and a draining write slot admits a new beat at full rate.
    assign px_in_ready = (state == RUN) && (!mem_wr_valid || mem_wr_ready);
    assign accept      = px_in_valid && px_in_ready;
    assign at_last_x   = (x == width);
    assign at_last_y   = (y == height);
    assign frame_error = accept && ((px_in_last_x != at_last_x) || (px_in_last_y != at_last_y));
    assign start_frame = start && ((state == IDLE) || (state == DONE));
    assign write_done  = mem_wr_valid && mem_wr_ready;

    // Frame sequencing: latch the resolution on start, leave RUN on the last
    // pixel accept and report done once its write has handshaken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done   <= 1'b0;
            width  <= '0;
            height <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        width  <= cfg_width;
                        height <= cfg_height;
                        done   <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (accept && at_last_x && at_last_y) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (write_done) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Raster position counters; the address follows these, never the incoming flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (start_frame) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            if (at_last_x) begin
                x <= '0;
                y <= y + Y_ONE;
            end else begin
                x <= x + X_ONE;
            end
        end
    end

    // Single-entry write slot: loaded on accept, held while the port stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_valid <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
        end else if (accept) begin
            mem_wr_valid <= 1'b1;
            mem_wr_addr  <= {y, x};
            mem_wr_data  <= px_in_data;
        end else if (mem_wr_ready) begin
            mem_wr_valid <= 1'b0;
        end
    end

    // Framing mismatch bookkeeping: sticky flag plus a saturating count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_framing <= 1'b0;
            err_count   <= '0;
        end else if (start_frame) begin
            err_framing <= 1'b0;
            err_count   <= '0;
        end else if (frame_error) begin
            err_framing <= 1'b1;
            if (err_count != E_MAX) begin
                err_count <= err_count + E_ONE;
            end
        end
    end

`ifdef PX_FRAME_WRITER_CHECKSUM_EN
    // Running modulo-2^16 sum of every accepted pixel in the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_sum <= '0;
        end else if (start_frame) begin
            frame_sum <= '0;
        end else if (accept) begin
            frame_sum <= frame_sum + 16'(px_in_data);
        end
    end
`else
`endif

endmodule
